// File: rtl/coproc_pkg.sv
// Shared field layout of the coprocessor instruction word and encoder FSM states.
// Word layout is the inverse of the coprocessor decode.
package coproc_pkg;
  localparam int INS_W       = 32;
  localparam int OPC_LSB     = 0;
  localparam int OPC_W       = 4;
  localparam int LOC_LSB     = 4;
  localparam int LOC_W       = 6;
  localparam int ID_LSB      = 10;
  localparam int ID_W        = 2;
  localparam int DATA_LO_LSB = 12;
  localparam int DATA_HI_LSB = 4;
  localparam int DATA_W      = 16;
  // Opcode bit selecting the short form (data packed low, no id/location).
  localparam int OPC_SEL_BIT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } enc_state_e;
endpackage

// File: rtl/instr_encoder_if.sv
// Command, operand and instruction-word handshakes of the instruction encoder.
// slave = encoder side, master = host side.
interface instr_encoder_if #(
  parameter int CNT_W = 6
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [1:0]       cmd_id;
  logic [5:0]       cmd_location;
  logic [CNT_W-1:0] cmd_count;
  logic             dat_valid;
  logic             dat_ready;
  logic [15:0]      dat_data;
  logic             ins_valid;
  logic             ins_ready;
  logic [31:0]      ins_word;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_id, cmd_location, cmd_count,
    input  dat_valid, dat_data, ins_ready,
    output cmd_ready, dat_ready, ins_valid, ins_word, busy
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_id, cmd_location, cmd_count,
    output dat_valid, dat_data, ins_ready,
    input  cmd_ready, dat_ready, ins_valid, ins_word, busy
  );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: opcode/id/location/data into one 32-bit instruction word.
module instr_field_pack
  import coproc_pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [ID_W-1:0]   i_id,
  input  logic [LOC_W-1:0]  i_location,
  input  logic [DATA_W-1:0] i_data,
  output logic [INS_W-1:0]  o_word
);
  always_comb begin
    o_word = '0;
    o_word[OPC_LSB +: OPC_W] = i_opcode;
    if (i_opcode[OPC_SEL_BIT]) begin
      o_word[DATA_HI_LSB +: DATA_W] = i_data;
    end else begin
      o_word[LOC_LSB +: LOC_W]      = i_location;
      o_word[ID_LSB +: ID_W]        = i_id;
      o_word[DATA_LO_LSB +: DATA_W] = i_data;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Burst instruction builder: one command, then one registered instruction word per
// operand with auto-incrementing location and a single-entry output register.
module instr_encoder
  import coproc_pkg::*;
#(
  parameter int LOC_LAST = 63,
  parameter int CNT_W    = 6
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  enc_state_e         r_state, w_nstate;
  logic [OPC_W-1:0]   r_opc;
  logic [ID_W-1:0]    r_id;
  logic [LOC_W-1:0]   r_loc;
  logic [CNT_W-1:0]   r_rem;
  logic               r_ins_valid;
  logic [INS_W-1:0]   r_ins_word;
  logic [INS_W-1:0]   w_packed;
  logic [LOC_W-1:0]   w_loc_nxt;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_slot_free, w_cmd_hs, w_dat_hs, w_last;

  instr_field_pack u_pack (
    .i_opcode   (r_opc),
    .i_id       (r_id),
    .i_location (r_loc),
    .i_data     (bus.dat_data),
    .o_word     (w_packed)
  );

  // Output slot frees when empty or when the held word is being taken this cycle.
  assign w_slot_free = !r_ins_valid || bus.ins_ready;
  assign w_cmd_hs    = (r_state == IDLE) && bus.cmd_valid;
  assign w_dat_hs    = (r_state == BURST) && w_slot_free && bus.dat_valid;
  assign w_last      = (r_rem == CNT_W'(1));
  assign w_cnt       = (bus.cmd_count == '0) ? CNT_W'(1) : bus.cmd_count;
  // Out-of-range start locations wrap to 0 on their first increment.
  assign w_loc_nxt   = (r_loc >= LOC_W'(LOC_LAST)) ? '0 : r_loc + LOC_W'(1);

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.dat_ready = (r_state == BURST) && w_slot_free;
  assign bus.ins_valid = r_ins_valid;
  assign bus.ins_word  = r_ins_word;
  assign bus.busy      = (r_state == BURST) || r_ins_valid;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_nstate = BURST;
      BURST:   if (w_dat_hs && w_last) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opc   <= '0;
      r_id    <= '0;
      r_loc   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_cmd_hs) begin
        r_opc <= bus.cmd_opcode;
        r_id  <= bus.cmd_id;
        r_loc <= bus.cmd_location;
        r_rem <= w_cnt;
      end else if (w_dat_hs) begin
        r_loc <= w_loc_nxt;
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_valid <= 1'b0;
      r_ins_word  <= '0;
    end else if (w_dat_hs) begin
      r_ins_valid <= 1'b1;
      r_ins_word  <= w_packed;
    end else if (bus.ins_ready) begin
      r_ins_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases from the plan plus randomized bursts
// against a word-level reference model.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.CNT_W(6)) bus ();

  instr_encoder #(.LOC_LAST(63), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] sb[$];
  int pop_t[$];

  // reference model state
  logic [3:0] m_op;
  logic [1:0] m_id;
  int m_loc;
  logic [31:0] m_last;

  bit rand_rdy = 1'b0;
  logic rdy_force = 1'b1;

  function automatic logic [31:0] ref_word(logic [3:0] op, logic [1:0] id, int loc, logic [15:0] d);
    if (op >= 4'd8) return 32'(op) + 32'(d) * 32'd16;
    return 32'(op) + 32'(loc) * 32'd16 + 32'(id) * 32'd1024 + 32'(d) * 32'd4096;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    bus.ins_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: pops an expected word on each output handshake; checks hold under stall.
  initial begin
    logic pend;
    logic [31:0] pw;
    pend = 1'b0;
    pw = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_valid", 32'(bus.ins_valid), 32'd1);
          chk("hold_word", bus.ins_word, pw);
        end
        if (bus.ins_valid && bus.ins_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", bus.ins_word);
          end else begin
            chk("sb_word", bus.ins_word, sb.pop_front());
          end
          pop_t.push_back(cyc);
        end
        pend = bus.ins_valid && !bus.ins_ready;
        pw = bus.ins_word;
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(logic [3:0] op, logic [1:0] id, logic [5:0] loc, logic [5:0] cnt);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_id = id;
    bus.cmd_location = loc;
    bus.cmd_count = cnt;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) fail_now("cmd_accept");
    m_op = op;
    m_id = id;
    m_loc = int'(loc);
  endtask

  task automatic send_data(logic [15:0] d);
    bit ok;
    ok = 1'b0;
    bus.dat_valid = 1'b1;
    bus.dat_data = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.dat_ready;
      @(posedge clk);
      if (ok) begin
        m_last = ref_word(m_op, m_id, m_loc, d);
        sb.push_back(m_last);
        m_loc = (m_loc + 1) % 64;
      end
      #1;
    end
    bus.dat_valid = 1'b0;
    if (!ok) fail_now("dat_accept");
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_id = '0;
    bus.cmd_location = '0;
    bus.cmd_count = '0;
    bus.dat_valid = 1'b0;
    bus.dat_data = '0;
    bus.ins_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_ins_word", bus.ins_word, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_dat_ready", 32'(bus.dat_ready), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // single word, one-cycle latency, back to IDLE
    send_cmd(4'h2, 2'd1, 6'd5, 6'd1);
    send_data(16'hABCD);
    chk("single_valid", 32'(bus.ins_valid), 32'd1);
    chk("single_word", bus.ins_word, 32'h0ABCD452);
    chk("single_idle", 32'(bus.cmd_ready), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    idle_cycles(2);
    chk("single_busy_clr", 32'(bus.busy), 32'd0);

    // short form
    send_cmd(4'h9, 2'd2, 6'd7, 6'd1);
    send_data(16'h1234);
    chk("hiop_word", bus.ins_word, 32'h00012349);
    idle_cycles(2);

    // wrap burst, back-to-back
    pop_t.delete();
    send_cmd(4'h1, 2'd3, 6'd62, 6'd3);
    send_data(16'h1);
    chk("wrap_w0", bus.ins_word, 32'h00001FE1);
    send_data(16'h2);
    chk("wrap_w1", bus.ins_word, 32'h00002FF1);
    send_data(16'h3);
    chk("wrap_w2", bus.ins_word, 32'h00003C01);
    idle_cycles(3);
    chk("wrap_npop", 32'(pop_t.size()), 32'd3);
    if (pop_t.size() == 3) chk("wrap_tput", 32'(pop_t[2] - pop_t[0]), 32'd2);

    // backpressure
    rdy_force = 1'b0;
    send_cmd(4'h6, 2'd2, 6'd30, 6'd4);
    send_data(16'hC0DE);
    bus.dat_valid = 1'b1;
    bus.dat_data = 16'h0001;
    repeat (4) begin
      @(negedge clk);
      chk("bp_dat_ready", 32'(bus.dat_ready), 32'd0);
      chk("bp_word", bus.ins_word, m_last);
      @(posedge clk);
      #1;
    end
    pop_t.delete();
    rdy_force = 1'b1;
    send_data(16'h0001);
    send_data(16'h0002);
    send_data(16'h0003);
    idle_cycles(3);
    chk("bp_npop", 32'(pop_t.size()), 32'd4);
    if (pop_t.size() == 4) chk("bp_tput", 32'(pop_t[3] - pop_t[0]), 32'd3);

    // count 0 means one word
    send_cmd(4'h7, 2'd1, 6'd40, 6'd0);
    send_data(16'h1111);
    chk("cnt0_idle", 32'(bus.cmd_ready), 32'd1);
    idle_cycles(2);

    // command during BURST is ignored
    send_cmd(4'h0, 2'd0, 6'd8, 6'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 4'hF;
    bus.cmd_location = 6'd50;
    bus.cmd_count = 6'd9;
    repeat (2) begin
      @(negedge clk);
      chk("burst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    send_data(16'hAAAA);
    send_data(16'hBBBB);
    chk("ign_idle", 32'(bus.cmd_ready), 32'd1);
    idle_cycles(2);

    // reset mid-burst with a word pending
    rdy_force = 1'b0;
    send_cmd(4'h5, 2'd0, 6'd10, 6'd5);
    send_data(16'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.ins_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mrst_dat_ready", 32'(bus.dat_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_force = 1'b1;
    idle_cycles(1);
    chk("post_rst_valid", 32'(bus.ins_valid), 32'd0);
    send_cmd(4'h3, 2'd2, 6'd20, 6'd2);
    send_data(16'h0055);
    chk("post_rst_word", bus.ins_word, 32'h00055943);
    send_data(16'h0066);
    idle_cycles(2);

    // randomized bursts with random output stalls
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int cnt;
      cnt = int'($urandom_range(0, 7));
      send_cmd(4'($urandom), 2'($urandom), 6'($urandom), 6'(cnt));
      for (int k = 0; k < ((cnt == 0) ? 1 : cnt); k++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
        send_data(16'($urandom));
      end
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    for (int i = 0; i < 100 && (sb.size() != 0 || bus.busy); i++) idle_cycles(1);
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
